// File: rtl/core_pipe_fetch_q.sv
// core_pipe_fetch_q - instruction fetch stage with pipelined memory requests.
//
// Issues MEM_BYTES-wide instruction memory requests (split grant/response,
// up to MAX_OUTSTANDING in flight), collects the returned halfwords in a
// BUF_BYTES parcel queue and presents the head instruction to decode.
// A control-flow change flushes the queue at once; responses still in
// flight for the old stream are counted in a discard counter and dropped.
//
// Optional feature macro: CORE_FETCH_RVC_EN
//   defined   - 16-bit compressed instructions are recognised and eaten.
//   undefined - 32-bit only; queue works in 4-byte units, cf_target[1]
//               is ignored, s2_eat_2 is ignored, s1_16bit is always 0.
//
// Ports:
//   g_clk, g_reset          clock, synchronous active-high reset
//   cf_valid/cf_ack/cf_target  control-flow change (cf_ack tied high)
//   imem_req/imem_addr/imem_gnt   request phase
//   imem_rsp/imem_err/imem_rdata  in-order response phase
//   s1_16bit/s1_32bit/s1_instr/s1_pc/s1_ferr  head instruction to decode
//   s2_eat_2/s2_eat_4       decode consumes 2 or 4 bytes
module core_pipe_fetch_q #(
  parameter int                XLEN             = 64,
  parameter logic [XLEN-1:0]   PC_RESET_ADDRESS = XLEN'(64'h8000_0000),
  parameter int                MEM_BYTES        = 8,
  parameter int                BUF_BYTES        = 16,
  parameter int                MAX_OUTSTANDING  = 2
) (
  input  logic                   g_clk,
  input  logic                   g_reset,
  input  logic                   cf_valid,
  output logic                   cf_ack,
  input  logic [XLEN-1:0]        cf_target,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rsp,
  input  logic                   imem_err,
  input  logic [8*MEM_BYTES-1:0] imem_rdata,
  output logic                   s1_16bit,
  output logic                   s1_32bit,
  output logic [31:0]            s1_instr,
  output logic [XLEN-1:0]        s1_pc,
  output logic [1:0]             s1_ferr,
  input  logic                   s2_eat_2,
  input  logic                   s2_eat_4
);

  localparam int OW = $clog2(MEM_BYTES);   // byte offset bits within a fetch
  localparam int MH = MEM_BYTES / 2;       // halfwords per response
  localparam int NH = BUF_BYTES / 2;       // halfwords in the queue
  localparam int CW = $clog2(NH + 1);      // queue occupancy width

  // Without compressed support a target's bit 1 is forced low.
  function automatic logic [XLEN-1:0] fix_target(input logic [XLEN-1:0] t);
`ifdef CORE_FETCH_RVC_EN
    return t;
`else
    return t & ~XLEN'(2);
`endif
  endfunction

  localparam logic [XLEN-1:0] RST_FIX = fix_target(PC_RESET_ADDRESS);

  logic [XLEN-1:0]        pc_r, addr_r;
  logic [OW-1:0]          skip_r;
  logic [2:0]             out_r, disc_r;
  logic [CW-1:0]          cnt_r;              // occupancy in halfwords
  logic [NH-1:0][15:0]    hw_r;               // entries >= cnt_r are kept zero
  logic [NH-1:0]          err_r;

  logic [XLEN-1:0]        tgt_s;
  logic                   rsp_s, gnt_s, app_en_s;
  logic [2:0]             out_n_s;
  logic [15:0]            fill_s;
  logic [1:0]             eat_s;
  logic [CW-1:0]          base_s, app_cnt_s, cnt_n_s;
  logic [8*MEM_BYTES-1:0] rsp_sh_s;
  logic [NH*16-1:0]       hw_sh_s, app_data_s;
  logic [NH-1:0]          err_sh_s, app_mask_s;
  logic [NH-1:0][15:0]    hw_n_s;
  logic [NH-1:0]          err_n_s;

  assign cf_ack   = 1'b1;
  assign tgt_s    = fix_target(cf_target);
  // A response with nothing outstanding is spurious and ignored.
  assign rsp_s    = imem_rsp && (out_r != 3'd0);
  assign gnt_s    = imem_req && imem_gnt;
  assign app_en_s = rsp_s && (disc_r == 3'd0) && !cf_valid;
  assign out_n_s  = out_r + {2'b00, gnt_s} - {2'b00, rsp_s};

  // Space reserved for every live (non-discarded) response plus this one.
  assign fill_s   = 16'({cnt_r, 1'b0}) + 16'(out_r - disc_r) * 16'(MEM_BYTES)
                  + 16'(MEM_BYTES);
  assign imem_req = !g_reset && !cf_valid && (out_r < 3'(MAX_OUTSTANDING))
                  && (fill_s <= 16'(BUF_BYTES));
  assign imem_addr = addr_r;
  assign s1_pc     = pc_r;
  assign s1_instr  = {hw_r[1], hw_r[0]};
  assign s1_ferr   = err_r[1:0];

`ifdef CORE_FETCH_RVC_EN
  assign s1_16bit = (cnt_r >= CW'(1)) && (hw_r[0][1:0] != 2'b11);
  assign s1_32bit = (cnt_r >= CW'(2)) && (hw_r[0][1:0] == 2'b11);
`else
  logic unused_eat2_s;
  assign unused_eat2_s = s2_eat_2;
  assign s1_16bit = 1'b0;
  assign s1_32bit = (cnt_r >= CW'(2));
`endif

  // Halfwords removed from the head this cycle; a redirect overrides eats.
  always_comb begin
    eat_s = 2'd0;
    if (cf_valid) begin
      eat_s = 2'd0;
    end else if (s2_eat_4 && (cnt_r >= CW'(2))) begin
      eat_s = 2'd2;
`ifdef CORE_FETCH_RVC_EN
    end else if (s2_eat_2 && (cnt_r >= CW'(1))) begin
      eat_s = 2'd1;
`endif
    end else begin
      eat_s = 2'd0;
    end
  end

  // Drain shifts the queue down; the response (minus skipped leading bytes)
  // lands right after the surviving entries.
  assign hw_sh_s    = hw_r >> {eat_s, 4'd0};
  assign err_sh_s   = err_r >> eat_s;
  assign base_s     = cnt_r - CW'(eat_s);
  assign rsp_sh_s   = imem_rdata >> {skip_r, 3'b000};
  assign app_data_s = {{(NH*16-8*MEM_BYTES){1'b0}}, rsp_sh_s} << {base_s, 4'd0};
  assign app_cnt_s  = CW'(MH) - CW'(skip_r[OW-1:1]);
  assign app_mask_s = (NH'({MH{1'b1}}) >> skip_r[OW-1:1]) << base_s;

  // Next queue contents: flush on redirect, else drain and/or append.
  always_comb begin
    hw_n_s  = hw_sh_s;
    err_n_s = err_sh_s;
    cnt_n_s = base_s;
    if (cf_valid) begin
      hw_n_s  = {(NH*16){1'b0}};
      err_n_s = {NH{1'b0}};
      cnt_n_s = {CW{1'b0}};
    end else if (app_en_s) begin
      hw_n_s  = hw_sh_s | app_data_s;
      err_n_s = err_sh_s | (app_mask_s & {NH{imem_err}});
      cnt_n_s = base_s + app_cnt_s;
    end else begin
      hw_n_s  = hw_sh_s;
      err_n_s = err_sh_s;
      cnt_n_s = base_s;
    end
  end

  // State update: PC, fetch address, skip, in-flight counters and queue.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      pc_r   <= PC_RESET_ADDRESS;
      addr_r <= PC_RESET_ADDRESS & ~XLEN'(MEM_BYTES - 1);
      skip_r <= RST_FIX[OW-1:0];
      out_r  <= 3'd0;
      disc_r <= 3'd0;
      cnt_r  <= {CW{1'b0}};
      hw_r   <= {(NH*16){1'b0}};
      err_r  <= {NH{1'b0}};
    end else begin
      out_r <= out_n_s;
      cnt_r <= cnt_n_s;
      hw_r  <= hw_n_s;
      err_r <= err_n_s;
      if (cf_valid) begin
        pc_r   <= tgt_s;
        addr_r <= tgt_s & ~XLEN'(MEM_BYTES - 1);
        skip_r <= tgt_s[OW-1:0];
        // Everything still in flight after this cycle belongs to the old
        // stream, including a request granted now; a response arriving now
        // is already consumed, whether or not it was itself stale.
        disc_r <= out_n_s;
      end else begin
        pc_r   <= pc_r + XLEN'({eat_s, 1'b0});
        addr_r <= gnt_s ? addr_r + XLEN'(MEM_BYTES) : addr_r;
        skip_r <= app_en_s ? {OW{1'b0}} : skip_r;
        disc_r <= (rsp_s && (disc_r != 3'd0)) ? disc_r - 3'd1 : disc_r;
      end
    end
  end

endmodule
